// File: rtl/cmac_op_ctrl.sv
// CMAC register-side operation controller: two ping-pong config groups, op_en/done
// producer protocol toward the core config stage, per-group done interrupts.
module cmac_op_ctrl (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rstn,
  input  logic        reg_wr_en,
  input  logic        reg_rd_en,
  input  logic [11:0] reg_offset,
  input  logic [31:0] reg_wr_data,
  output logic [31:0] reg_rd_data,
  output logic        reg_rd_valid,
  input  logic        dp2reg_done,
  output logic        reg2dp_op_en,
  output logic        reg2dp_conv_mode,
  output logic [1:0]  reg2dp_proc_precision,
  output logic [1:0]  cmac2glb_done_intr_pd
);

  localparam logic [9:0] ADDR_STATUS  = 10'h000;
  localparam logic [9:0] ADDR_POINTER = 10'h001;
  localparam logic [9:0] ADDR_OP_EN   = 10'h002;
  localparam logic [9:0] ADDR_MISC    = 10'h003;

  logic [1:0]      op_en;
  logic [1:0]      conv_mode;
  logic [1:0][1:0] precision;
  logic            prod;
  logic            cons;
  logic            done_err;
  logic [1:0]      intr;

  logic [9:0]  addr;
  logic        wr_status, wr_pointer, wr_op_en, wr_misc;
  logic        locked;
  logic        done_ok, done_bad;
  logic [1:0]  status_0, status_1;
  logic [31:0] rd_mux;

  assign addr = reg_offset[11:2];

  // Handshake: reg_rd_en is a one-cycle request; reg_rd_valid pulses exactly one
  // cycle later with reg_rd_data, which then holds until the next read.
  always_comb begin
    wr_status  = reg_wr_en && (addr == ADDR_STATUS);
    wr_pointer = reg_wr_en && (addr == ADDR_POINTER);
    wr_op_en   = reg_wr_en && (addr == ADDR_OP_EN);
    wr_misc    = reg_wr_en && (addr == ADDR_MISC);
    locked     = op_en[prod];
    done_ok    = dp2reg_done && op_en[cons];
    done_bad   = dp2reg_done && !op_en[cons];
    status_0   = op_en[0] ? ((cons == 1'b0) ? 2'd1 : 2'd2) : 2'd0;
    status_1   = op_en[1] ? ((cons == 1'b1) ? 2'd1 : 2'd2) : 2'd0;
    rd_mux     = 32'h0;
    case (addr)
      ADDR_STATUS:  rd_mux = {14'h0, status_1, 7'h0, done_err, 6'h0, status_0};
      ADDR_POINTER: rd_mux = {15'h0, cons, 15'h0, prod};
      ADDR_OP_EN:   rd_mux = {31'h0, op_en[prod]};
      ADDR_MISC:    rd_mux = {18'h0, precision[prod], 11'h0, conv_mode[prod]};
      default:      rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      op_en        <= 2'b00;
      conv_mode    <= 2'b00;
      precision    <= {2'b01, 2'b01};
      prod         <= 1'b0;
      cons         <= 1'b0;
      done_err     <= 1'b0;
      intr         <= 2'b00;
      reg_rd_valid <= 1'b0;
      reg_rd_data  <= 32'h0;
    end else begin
      if (wr_pointer) prod <= reg_wr_data[0];
      // Lock uses pre-edge op_en, so a write racing a done on the same group is lost.
      if (wr_op_en && !locked) op_en[prod] <= reg_wr_data[0];
      if (wr_misc && !locked) begin
        conv_mode[prod] <= reg_wr_data[0];
        precision[prod] <= reg_wr_data[13:12];
      end
      if (done_ok) begin
        op_en[cons] <= 1'b0;
        cons        <= ~cons;
      end
      intr <= done_ok ? (cons ? 2'b10 : 2'b01) : 2'b00;
      if (done_bad) done_err <= 1'b1;
      else if (wr_status && reg_wr_data[8]) done_err <= 1'b0;
      reg_rd_valid <= reg_rd_en;
      if (reg_rd_en) reg_rd_data <= rd_mux;
    end
  end

  assign reg2dp_op_en          = op_en[cons];
  assign reg2dp_conv_mode      = conv_mode[cons];
  assign reg2dp_proc_precision = precision[cons];
  assign cmac2glb_done_intr_pd = intr;

  logic unused_bits;
  assign unused_bits = ^{reg_offset[1:0], reg_wr_data[31:14], reg_wr_data[11:9], reg_wr_data[7:1]};

endmodule

// File: tb/tb_cmac_op_ctrl.sv
// Directed bench for cmac_op_ctrl: read results go through an expected queue,
// output and interrupt checks are immediate assertions.
module tb_cmac_op_ctrl;

  localparam logic [11:0] OFF_STATUS  = 12'h000;
  localparam logic [11:0] OFF_POINTER = 12'h004;
  localparam logic [11:0] OFF_OP_EN   = 12'h008;
  localparam logic [11:0] OFF_MISC    = 12'h00C;
  localparam logic [11:0] OFF_UNMAP   = 12'h010;

  logic        nvdla_core_clk = 1'b0;
  logic        nvdla_core_rstn = 1'b0;
  logic        reg_wr_en = 1'b0;
  logic        reg_rd_en = 1'b0;
  logic [11:0] reg_offset = 12'h0;
  logic [31:0] reg_wr_data = 32'h0;
  logic [31:0] reg_rd_data;
  logic        reg_rd_valid;
  logic        dp2reg_done = 1'b0;
  logic        reg2dp_op_en;
  logic        reg2dp_conv_mode;
  logic [1:0]  reg2dp_proc_precision;
  logic [1:0]  cmac2glb_done_intr_pd;

  logic [31:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  cmac_op_ctrl dut (
    .nvdla_core_clk       (nvdla_core_clk),
    .nvdla_core_rstn      (nvdla_core_rstn),
    .reg_wr_en            (reg_wr_en),
    .reg_rd_en            (reg_rd_en),
    .reg_offset           (reg_offset),
    .reg_wr_data          (reg_wr_data),
    .reg_rd_data          (reg_rd_data),
    .reg_rd_valid         (reg_rd_valid),
    .dp2reg_done          (dp2reg_done),
    .reg2dp_op_en         (reg2dp_op_en),
    .reg2dp_conv_mode     (reg2dp_conv_mode),
    .reg2dp_proc_precision(reg2dp_proc_precision),
    .cmac2glb_done_intr_pd(cmac2glb_done_intr_pd)
  );

  // clock / reset
  always #5 nvdla_core_clk = ~nvdla_core_clk;

  task automatic reset_dut();
    nvdla_core_rstn = 1'b0;
    repeat (2) @(negedge nvdla_core_clk);
    nvdla_core_rstn = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_out(input string tag, input logic op, input logic cm, input logic [1:0] pr);
    chk({tag, "_op_en"}, {31'h0, reg2dp_op_en}, {31'h0, op});
    chk({tag, "_conv"}, {31'h0, reg2dp_conv_mode}, {31'h0, cm});
    chk({tag, "_prec"}, {30'h0, reg2dp_proc_precision}, {30'h0, pr});
  endtask

  // driver tasks
  task automatic wr(input logic [11:0] off, input logic [31:0] d);
    @(negedge nvdla_core_clk);
    reg_wr_en   = 1'b1;
    reg_offset  = off;
    reg_wr_data = d;
    @(negedge nvdla_core_clk);
    reg_wr_en   = 1'b0;
    reg_wr_data = $urandom;
    reg_offset  = 12'($urandom_range(0, 4095));
  endtask

  task automatic rd(input logic [11:0] off, input logic [31:0] e, input string tag);
    int n;
    exp_q.push_back(e);
    @(negedge nvdla_core_clk);
    reg_rd_en  = 1'b1;
    reg_offset = off;
    @(negedge nvdla_core_clk);
    reg_rd_en  = 1'b0;
    n = 0;
    while (!reg_rd_valid && n < 4) begin
      @(negedge nvdla_core_clk);
      n++;
    end
    chk({tag, "_vld"}, {31'h0, reg_rd_valid}, 32'h1);
    chk(tag, reg_rd_data, exp_q.pop_front());
  endtask

  task automatic done_pulse(input logic [1:0] exp_intr, input string tag);
    @(negedge nvdla_core_clk);
    dp2reg_done = 1'b1;
    @(negedge nvdla_core_clk);
    dp2reg_done = 1'b0;
    chk({tag, "_intr"}, {30'h0, cmac2glb_done_intr_pd}, {30'h0, exp_intr});
    @(negedge nvdla_core_clk);
    chk({tag, "_intr_off"}, {30'h0, cmac2glb_done_intr_pd}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    reset_dut();
    chk_out("rst", 1'b0, 1'b0, 2'b01);
    chk("rst_intr", {30'h0, cmac2glb_done_intr_pd}, 32'h0);
    chk("rst_rd_valid", {31'h0, reg_rd_valid}, 32'h0);
    chk("rst_rd_data", reg_rd_data, 32'h0);
    rd(OFF_STATUS, 32'h0, "rst_status");
    rd(OFF_POINTER, 32'h0, "rst_pointer");
    rd(OFF_OP_EN, 32'h0, "rst_op_en");
    rd(OFF_MISC, 32'h0000_1000, "rst_misc");
    rd(OFF_UNMAP, 32'h0, "rst_unmapped");

    // single op on group 0, with lock checks while running
    wr(OFF_MISC, 32'h0000_2001);
    chk_out("cfg_g0", 1'b0, 1'b1, 2'b10);
    wr(OFF_OP_EN, 32'h1);
    chk_out("run_g0", 1'b1, 1'b1, 2'b10);
    rd(OFF_STATUS, 32'h0000_0001, "run_status");
    wr(OFF_MISC, 32'h0);
    rd(OFF_MISC, 32'h0000_2001, "lock_misc");
    wr(OFF_OP_EN, 32'h0);
    chk_out("lock_out", 1'b1, 1'b1, 2'b10);
    repeat (5) @(negedge nvdla_core_clk);
    done_pulse(2'b01, "single_done");
    chk_out("single_after", 1'b0, 1'b0, 2'b01);
    rd(OFF_POINTER, 32'h0001_0000, "single_pointer");

    // ping-pong: g0 running, g1 pending
    reset_dut();
    wr(OFF_MISC, 32'h0);
    wr(OFF_OP_EN, 32'h1);
    wr(OFF_POINTER, 32'h1);
    wr(OFF_MISC, 32'h0000_2000);
    wr(OFF_OP_EN, 32'h1);
    rd(OFF_STATUS, 32'h0002_0001, "pp_status");
    chk_out("pp_g0", 1'b1, 1'b0, 2'b00);
    done_pulse(2'b01, "pp_done0");
    chk_out("pp_g1", 1'b1, 1'b0, 2'b10);
    rd(OFF_POINTER, 32'h0001_0001, "pp_pointer");
    done_pulse(2'b10, "pp_done1");
    chk_out("pp_idle", 1'b0, 1'b0, 2'b00);
    rd(OFF_STATUS, 32'h0, "pp_status_idle");

    // back-to-back dones: two retire, third is spurious
    wr(OFF_OP_EN, 32'h1);
    wr(OFF_POINTER, 32'h0);
    wr(OFF_OP_EN, 32'h1);
    @(negedge nvdla_core_clk);
    dp2reg_done = 1'b1;
    @(negedge nvdla_core_clk);
    chk("b2b_intr0", {30'h0, cmac2glb_done_intr_pd}, 32'h1);
    @(negedge nvdla_core_clk);
    chk("b2b_intr1", {30'h0, cmac2glb_done_intr_pd}, 32'h2);
    @(negedge nvdla_core_clk);
    dp2reg_done = 1'b0;
    chk("b2b_intr2", {30'h0, cmac2glb_done_intr_pd}, 32'h0);
    rd(OFF_STATUS, 32'h0000_0100, "b2b_err");
    rd(OFF_POINTER, 32'h0, "b2b_pointer");

    // spurious done and W1C of done_err
    wr(OFF_STATUS, 32'h0000_0100);
    rd(OFF_STATUS, 32'h0, "w1c_clear");
    done_pulse(2'b00, "spurious");
    rd(OFF_STATUS, 32'h0000_0100, "spurious_err");
    rd(OFF_POINTER, 32'h0, "spurious_pointer");
    @(negedge nvdla_core_clk);
    dp2reg_done = 1'b1;
    reg_wr_en   = 1'b1;
    reg_offset  = OFF_STATUS;
    reg_wr_data = 32'h0000_0100;
    @(negedge nvdla_core_clk);
    dp2reg_done = 1'b0;
    reg_wr_en   = 1'b0;
    rd(OFF_STATUS, 32'h0000_0100, "set_beats_w1c");
    wr(OFF_STATUS, 32'h0000_0100);
    rd(OFF_STATUS, 32'h0, "w1c_clear2");

    // done and locked write to the same group in one cycle: write is lost
    wr(OFF_OP_EN, 32'h1);
    @(negedge nvdla_core_clk);
    dp2reg_done = 1'b1;
    reg_wr_en   = 1'b1;
    reg_offset  = OFF_MISC;
    reg_wr_data = 32'h0000_3001;
    @(negedge nvdla_core_clk);
    dp2reg_done = 1'b0;
    reg_wr_en   = 1'b0;
    chk("race_intr", {30'h0, cmac2glb_done_intr_pd}, 32'h1);
    chk_out("race_out", 1'b0, 1'b0, 2'b10);
    rd(OFF_MISC, 32'h0, "race_misc");

    // asynchronous reset mid-op
    reset_dut();
    wr(OFF_OP_EN, 32'h1);
    wr(OFF_POINTER, 32'h1);
    wr(OFF_MISC, 32'h0000_2001);
    wr(OFF_OP_EN, 32'h1);
    rd(OFF_STATUS, 32'h0002_0001, "mid_status");
    chk_out("mid_run", 1'b1, 1'b0, 2'b01);
    @(negedge nvdla_core_clk);
    #2 nvdla_core_rstn = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 1'b0, 2'b01);
    chk("async_intr", {30'h0, cmac2glb_done_intr_pd}, 32'h0);
    chk("async_rd_valid", {31'h0, reg_rd_valid}, 32'h0);
    chk("async_rd_data", reg_rd_data, 32'h0);
    @(negedge nvdla_core_clk);
    nvdla_core_rstn = 1'b1;
    done_pulse(2'b00, "post_rst_done");
    rd(OFF_STATUS, 32'h0000_0100, "post_rst_err");
    rd(OFF_POINTER, 32'h0, "post_rst_pointer");

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
